assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache between the LC-3b datapath (16-bit word port) and physical memory (one line per burst). It generalises the fixed 2-way/8-set design to configurable WAYS and SETS. It uses tree pseudo-LRU replacement and adds saturating hit/miss counters for performance measurement.

---
 rtl/assoc_cache_pkg.sv | 31 +++
 rtl/assoc_cache_if.sv | 40 ++++
 rtl/assoc_cache_plru_tree.sv | 35 +++
 rtl/assoc_cache.sv | 181 ++++++++++++++++++
 tb/tb_assoc_cache.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/assoc_cache_pkg.sv
// Shared types and geometry helpers for the set-associative cache.
//   WORD_W      : CPU word width (16)
//   word_t/be_t : CPU data word and byte-lane enable types
//   state_t     : controller states
//   off_w/idx_w/tag_w/line_w : address-split and line widths from the parameters
package assoc_cache_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [WORD_W/8-1:0] be_t;

  typedef enum logic [1:0] {IDLE, RESP, WRITEBACK, FILL} state_t;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
    return addr_w - off_w(line_bytes) - idx_w(sets);
  endfunction

  function automatic int line_w(input int line_bytes);
    return 8 * line_bytes;
  endfunction

endpackage

// File: rtl/assoc_cache_if.sv
// CPU-side word port and physical-memory line port of the cache.
//   slave  : the cache (takes CPU requests, drives pmem requests)
//   master : the environment (CPU + physical memory)
interface assoc_cache_if
  import assoc_cache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int LINE_BYTES = 16
);

  logic                    mem_read;
  logic                    mem_write;
  be_t                     mem_byte_enable;
  logic [ADDR_W-1:0]       mem_address;
  word_t                   mem_wdata;
  logic                    mem_resp;
  word_t                   mem_rdata;

  logic                    pmem_read;
  logic                    pmem_write;
  logic [ADDR_W-1:0]       pmem_address;
  logic [8*LINE_BYTES-1:0] pmem_wdata;
  logic [8*LINE_BYTES-1:0] pmem_rdata;
  logic                    pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/assoc_cache_plru_tree.sv
// Tree pseudo-LRU for one set (combinational).
//   bits_in    : current WAYS-1 node bits (heap order: node n -> children 2n+1, 2n+2)
//   access_way : way being used
//   bits_out   : node bits after touching access_way
//   victim     : way reached by following bits_in
// A node bit of 0 points at the lower half (victim side), 1 at the upper half.
module plru_tree #(
  parameter int WAYS = 2
) (
  input  logic [WAYS-2:0]         bits_in,
  input  logic [$clog2(WAYS)-1:0] access_way,
  output logic [WAYS-2:0]         bits_out,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int LEVELS = $clog2(WAYS);

  always_comb begin
    int unsigned node_u;
    int unsigned node_v;
    bits_out = bits_in;
    victim   = '0;
    node_u   = 0;
    node_v   = 0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      bits_out[node_u] = ~access_way[LEVELS-1-l];
      node_u = 2 * node_u + 1 + {31'b0, access_way[LEVELS-1-l]};
    end
    for (int unsigned l = 0; l < LEVELS; l++) begin
      victim[LEVELS-1-l] = bits_in[node_v];
      node_v = 2 * node_v + 1 + {31'b0, bits_in[node_v]};
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back, write-allocate cache with tree PLRU.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : CPU word port + physical-memory line port (slave side)
//   hit_count   : saturating count of first-lookup hits
//   miss_count  : saturating count of first-lookup misses
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int ADDR_W     = 16,
  parameter int LINE_BYTES = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  assoc_cache_if.slave     bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int OFF_W  = off_w(LINE_BYTES);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_BYTES);
  localparam int LINE_W = line_w(LINE_BYTES);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WSEL_W = OFF_W - 1;

  typedef logic [LINE_W-1:0] line_t;

  logic [TAG_W-1:0]               tag_arr  [WAYS][SETS];
  line_t                          data_arr [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0]      valid, dirty;
  logic [SETS-1:0][WAYS-2:0]      plru;

  state_t            state, next_state;
  logic              req, hit, has_inv, relook;
  logic [WAY_W-1:0]  hit_way, inv_way, plru_vict, vict_way, vict_q;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] wsel;
  logic [WAYS-2:0]   plru_upd;
  word_t             cur_word, rdata_q;
  logic              unused_addr_lsb;

  assign req             = bus.mem_read | bus.mem_write;
  assign idx             = bus.mem_address[OFF_W +: IDX_W];
  assign req_tag         = bus.mem_address[ADDR_W-1 -: TAG_W];
  assign wsel            = bus.mem_address[OFF_W-1:1];
  assign unused_addr_lsb = bus.mem_address[0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid[w][idx] && tag_arr[w][idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid[w-1][idx]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w - 1);
      end
    end
  end

  assign vict_way = has_inv ? inv_way : plru_vict;
  assign cur_word = data_arr[hit_way][idx][wsel*WORD_W +: WORD_W];

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_in    (plru[idx]),
    .access_way (hit_way),
    .bits_out   (plru_upd),
    .victim     (plru_vict)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state       = state;
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit)                                             next_state = RESP;
          else if (valid[vict_way][idx] && dirty[vict_way][idx]) next_state = WRITEBACK;
          else                                                 next_state = FILL;
        end
      end
      RESP: begin
        bus.mem_resp = 1'b1;
        next_state   = IDLE;
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_arr[vict_q][idx], idx, {OFF_W{1'b0}}};
        bus.pmem_wdata   = data_arr[vict_q][idx];
        if (bus.pmem_resp) next_state = FILL;
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {req_tag, idx, {OFF_W{1'b0}}};
        if (bus.pmem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // relook marks the lookup after a fill so it is not counted a second time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      dirty      <= '0;
      plru       <= '0;
      vict_q     <= '0;
      rdata_q    <= '0;
      relook     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (!relook) begin
              if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
              end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
              end
            end
            if (hit) begin
              relook    <= 1'b0;
              plru[idx] <= plru_upd;
              if (bus.mem_read) rdata_q <= cur_word;
              else              dirty[hit_way][idx] <= 1'b1;
            end else begin
              vict_q <= vict_way;
            end
          end
        end
        WRITEBACK: if (bus.pmem_resp) dirty[vict_q][idx] <= 1'b0;
        FILL: begin
          if (bus.pmem_resp) begin
            valid[vict_q][idx] <= 1'b1;
            dirty[vict_q][idx] <= 1'b0;
            relook             <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && hit && !bus.mem_read && bus.mem_write) begin
      for (int unsigned b = 0; b < WORD_W / 8; b++) begin
        if (bus.mem_byte_enable[b])
          data_arr[hit_way][idx][wsel*WORD_W + b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
    end
    if (state == FILL && bus.pmem_resp) begin
      data_arr[vict_q][idx] <= bus.pmem_rdata;
      tag_arr[vict_q][idx]  <= req_tag;
    end
  end

  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (4 ways, 8 sets, 16-byte lines, 3-bit counters).
// Physical memory is a bench-side array answering after LAT cycles.
module tb_assoc_cache;
  import assoc_cache_pkg::*;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] hit_count, miss_count;

  int n_checks = 0;
  int n_errors = 0;

  int           pm_reads = 0;
  int           pm_writes = 0;
  logic [15:0]  last_rd_addr = '0;
  logic [15:0]  last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;
  logic [127:0] mem [4096];

  assoc_cache_if #(.ADDR_W(16), .LINE_BYTES(16)) bus ();

  assoc_cache #(
    .WAYS(4), .SETS(8), .ADDR_W(16), .LINE_BYTES(16), .CNT_W(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hA55A;
  endfunction

  initial begin
    for (int unsigned l = 0; l < 4096; l++)
      for (int unsigned w = 0; w < 8; w++)
        mem[l][16*w +: 16] = pat(16'(l*16 + w*2));
  end

  // Physical memory: respond on the LAT-th cycle a request has been seen.
  initial begin
    int wait_cnt;
    wait_cnt        = 0;
    bus.pmem_resp   = 1'b0;
    bus.pmem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.pmem_resp || !rst_n) begin
        bus.pmem_resp = 1'b0;
        wait_cnt      = 0;
      end
      if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
        check("pmem_excl", bus.pmem_read & bus.pmem_write, 1'b0);
        wait_cnt++;
        if (wait_cnt == LAT) begin
          if (bus.pmem_read) begin
            bus.pmem_rdata = mem[bus.pmem_address[15:4]];
            pm_reads++;
            last_rd_addr = bus.pmem_address;
          end else begin
            mem[bus.pmem_address[15:4]] = bus.pmem_wdata;
            pm_writes++;
            last_wr_addr = bus.pmem_address;
            last_wr_data = bus.pmem_wdata;
          end
          bus.pmem_resp = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // cyc counts cycles with the request cycle as 1; the response cycle is reported.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        output logic [15:0] rdata, output int cyc);
    logic done;
    done  = 1'b0;
    rdata = '0;
    cyc   = 0;
    @(posedge clk); #1;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = be;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_resp) begin
        done  = 1'b1;
        rdata = bus.mem_rdata;
      end
    end
    check("resp_seen", done, 1'b1);
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("resp_pulse", bus.mem_resp, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0]  d;
    logic [127:0] wl;
    int           c, r0, w0;
    logic         found;

    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_resp",   bus.mem_resp,     1'b0);
    check("rst_pmem_read",  bus.pmem_read,    1'b0);
    check("rst_pmem_write", bus.pmem_write,   1'b0);
    check("rst_mem_rdata",  bus.mem_rdata,    16'h0000);
    check("rst_pmem_addr",  bus.pmem_address, 16'h0000);
    check("rst_hits",       hit_count,        3'd0);
    check("rst_misses",     miss_count,       3'd0);
    rst_n = 1'b1;

    // Cold read miss
    r0 = pm_reads; w0 = pm_writes;
    access(1, 0, 16'h0002, 16'h0, 2'b00, d, c);
    check("miss_rdata",   d, 16'hA75A);
    check("miss_lat",     c, 6);
    check("miss_fills",   pm_reads - r0, 1);
    check("miss_fill_ad", last_rd_addr, 16'h0000);
    check("miss_no_wb",   pm_writes - w0, 0);
    check("miss_cnt1",    miss_count, 3'd1);
    check("miss_hit0",    hit_count, 3'd0);

    // Read hit
    r0 = pm_reads;
    access(1, 0, 16'h0002, 16'h0, 2'b00, d, c);
    check("hit_rdata", d, 16'hA75A);
    check("hit_lat",   c, 2);
    check("hit_nopm",  pm_reads - r0, 0);
    check("hit_cnt1",  hit_count, 3'd1);

    // High-byte write then read back
    access(0, 1, 16'h0002, 16'h600D, 2'b10, d, c);
    check("wr_lat", c, 2);
    access(1, 0, 16'h0002, 16'h0, 2'b00, d, c);
    check("wr_hi_byte", d, 16'h605A);
    access(1, 0, 16'h000E, 16'h0, 2'b00, d, c);
    check("word7_rdata", d, 16'hAB5A);

    // Dirty eviction of line 0x0000 (ways 1..3 filled, PLRU victim way 0)
    access(0, 1, 16'h0000, 16'h1234, 2'b11, d, c);
    access(1, 0, 16'h0080, 16'h0, 2'b00, d, c);
    check("t1_rdata", d, 16'h255A);
    access(1, 0, 16'h0100, 16'h0, 2'b00, d, c);
    access(1, 0, 16'h0180, 16'h0, 2'b00, d, c);
    r0 = pm_reads; w0 = pm_writes;
    access(1, 0, 16'h0200, 16'h0, 2'b00, d, c);
    wl = last_wr_data;
    check("ev_rdata",   d, 16'hA558);
    check("ev_lat",     c, 9);
    check("ev_wbs",     pm_writes - w0, 1);
    check("ev_wb_addr", last_wr_addr, 16'h0000);
    check("ev_wb_w0",   wl[15:0], 16'h1234);
    check("ev_wb_w1",   wl[31:16], 16'h605A);
    check("ev_fill_ad", last_rd_addr, 16'h0200);
    check("ev_fills",   pm_reads - r0, 1);

    // Re-fetch the written-back line (clean victim way 2)
    w0 = pm_writes;
    access(1, 0, 16'h0000, 16'h0, 2'b00, d, c);
    check("refetch_rdata", d, 16'h1234);
    check("refetch_lat",   c, 6);
    check("refetch_no_wb", pm_writes - w0, 0);
    check("cnt_miss6", miss_count, 3'd6);
    check("cnt_hit5",  hit_count, 3'd5);

    // Read and write together: read wins, line unchanged
    access(1, 1, 16'h0000, 16'hDEAD, 2'b11, d, c);
    check("rw_rdata", d, 16'h1234);
    access(1, 0, 16'h0000, 16'h0, 2'b00, d, c);
    check("rw_nowrite", d, 16'h1234);
    access(1, 0, 16'h0000, 16'h0, 2'b00, d, c);
    check("hit_sat", hit_count, 3'd7);
    check("miss_hold", miss_count, 3'd6);

    // PLRU on a clean set: tags 0..3 then tag 4 evicts way 0
    do_reset();
    check("rst2_hits",   hit_count, 3'd0);
    check("rst2_misses", miss_count, 3'd0);
    access(1, 0, 16'h0000, 16'h0, 2'b00, d, c);
    access(1, 0, 16'h0080, 16'h0, 2'b00, d, c);
    access(1, 0, 16'h0100, 16'h0, 2'b00, d, c);
    access(1, 0, 16'h0180, 16'h0, 2'b00, d, c);
    r0 = pm_reads; w0 = pm_writes;
    access(1, 0, 16'h0200, 16'h0, 2'b00, d, c);
    check("plru_fill_ad", last_rd_addr, 16'h0200);
    check("plru_fills",   pm_reads - r0, 1);
    check("plru_no_wb",   pm_writes - w0, 0);
    access(1, 0, 16'h0080, 16'h0, 2'b00, d, c);
    check("plru_keep1", c, 2);
    access(1, 0, 16'h0000, 16'h0, 2'b00, d, c);
    check("plru_evict0", c, 6);

    // Reset during FILL
    @(posedge clk); #1;
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h0300;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.pmem_read) found = 1'b1;
    end
    check("rf_fill_seen", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rf_pmem_read",  bus.pmem_read, 1'b0);
    check("rf_pmem_write", bus.pmem_write, 1'b0);
    check("rf_pmem_addr",  bus.pmem_address, 16'h0000);
    bus.mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rf_hits0",   hit_count, 3'd0);
    check("rf_misses0", miss_count, 3'd0);
    access(1, 0, 16'h0300, 16'h0, 2'b00, d, c);
    check("rf_rdata",  d, 16'hA559);
    check("rf_lat",    c, 6);
    check("rf_miss1",  miss_count, 3'd1);
    check("rf_hit0",   hit_count, 3'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
